dp_skid_reg: RTL and testbench

Two-entry registered skid buffer for the datapath. It sits directly downstream of the `or2` datapath cell in the `dpath1` group and captures its `Y` output as a valid/ready stream for the next stage. All outputs come from flops, which cuts the combinational path between the OR stage and its consumer. It sustains one word per cycle and absorbs a single cycle of downstream back-pressure without losing data.

---
 rtl/dp_skid_reg_if.sv | 50 +++++
 rtl/dp_skid_reg.sv | 113 +++++++++++
 tb/tb_dp_skid_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dp_skid_reg_if.sv
// ---------------------------------------------------------------------------
// dp_skid_reg_if
// Valid/ready bundle around the dp_skid_reg buffer. Carries both the upstream
// side (word coming from the or2 Y output) and the downstream side (word going
// to the next stage).
//
// Handshake semantics (both sides): a word moves on a rising clock edge where
// VALID and READY are both 1. The producer may raise or drop VALID freely;
// READY may be high while VALID is low, which is harmless.
//
// Signals:
//   DIN        [N-1:0]  upstream data
//   DIN_VALID           upstream word present
//   DIN_READY           buffer can take a word
//   DOUT       [N-1:0]  head-of-buffer word
//   DOUT_VALID          DOUT holds a word
//   DOUT_READY          downstream takes DOUT
//
// Modports:
//   slave  - the buffer itself
//   master - the environment driving the buffer (upstream + downstream)
// ---------------------------------------------------------------------------
interface dp_skid_reg_if #(
  parameter int N = 8
);
  logic [N-1:0] DIN;
  logic         DIN_VALID;
  logic         DIN_READY;
  logic [N-1:0] DOUT;
  logic         DOUT_VALID;
  logic         DOUT_READY;

  modport slave (
    input  DIN,
    input  DIN_VALID,
    input  DOUT_READY,
    output DIN_READY,
    output DOUT,
    output DOUT_VALID
  );

  modport master (
    output DIN,
    output DIN_VALID,
    output DOUT_READY,
    input  DIN_READY,
    input  DOUT,
    input  DOUT_VALID
  );
endinterface

// File: rtl/dp_skid_reg.sv
// ---------------------------------------------------------------------------
// dp_skid_reg
// Two-entry registered skid buffer placed after the or2 cell of the dpath1
// group. Every output comes straight from a flop, so the combinational path
// from the OR stage to its consumer is cut. Streams one word per cycle and
// absorbs one cycle of downstream back-pressure in the skid register.
//
// Parameters:
//   N       datapath width
//   DPFLAG  placement flag, no functional effect
//   GROUP   datapath group name, no functional effect
//   d_OUT   simulation output delay, no cycle-level effect
//
// Ports:
//   CLK  in   rising-edge clock
//   RST  in   synchronous active-high reset
//   bus  slave modport of dp_skid_reg_if (DIN/DIN_VALID/DIN_READY,
//        DOUT/DOUT_VALID/DOUT_READY)
//   OCC  out  occupancy 0..2, equal to the FSM state (debug/state view)
// ---------------------------------------------------------------------------
module dp_skid_reg #(
  parameter int N      = 8,
  parameter bit DPFLAG = 1'b1,
  parameter     GROUP  = "dpath1",
  parameter int d_OUT  = 1
) (
  input  logic                CLK,
  input  logic                RST,
  dp_skid_reg_if.slave        bus,
  output logic [1:0]          OCC
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] m_q, m_d;        // main register, drives DOUT
  logic [N-1:0] s_q, s_d;        // skid register, only holds data when FULL
  logic         dout_valid_q;
  logic         din_ready_q;

  logic         accept;
  logic         deliver;

  // Metadata parameters are carried for the datapath flow only.
  logic unused_params;
  assign unused_params = DPFLAG ^ (d_OUT != 0) ^ (GROUP == "dpath1");

  assign accept  = bus.DIN_VALID & din_ready_q;
  assign deliver = dout_valid_q  & bus.DOUT_READY;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          m_d     = bus.DIN;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          // Occupancy unchanged, head word replaced.
          m_d = bus.DIN;
        end else if (accept) begin
          state_d = FULL;
          s_d     = bus.DIN;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // DIN_READY is low here, so only a deliver can happen.
        if (deliver) begin
          state_d = ONE;
          m_d     = s_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= EMPTY;
      m_q          <= '0;
      s_q          <= '0;
      dout_valid_q <= 1'b0;
      din_ready_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      s_q          <= s_d;
      // Handshake flags are registered copies of the next-state decode.
      dout_valid_q <= (state_d != EMPTY);
      din_ready_q  <= (state_d != FULL);
    end
  end

  assign bus.DOUT       = m_q;
  assign bus.DOUT_VALID = dout_valid_q;
  assign bus.DIN_READY  = din_ready_q;
  assign OCC            = state_q;

endmodule

// File: tb/tb_dp_skid_reg.sv
module tb_dp_skid_reg;

  localparam int N = 8;

  // ---------------- clock / reset ----------------
  logic CLK;
  logic RST;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  dp_skid_reg_if #(.N(N)) bus ();
  logic [1:0] OCC;

  dp_skid_reg #(.N(N)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus),
    .OCC (OCC)
  );

  // ---------------- reference model ----------------
  // The buffer behaves as a FIFO of capacity 2: it takes a word when it holds
  // fewer than 2, shows the oldest word, and keeps showing the last delivered
  // word once it runs empty.
  logic [N-1:0] exp_q[$];
  logic [N-1:0] last_out;

  int n_pass;
  int n_total;

  function automatic logic [N-1:0] exp_dout();
    if (exp_q.size() > 0) return exp_q[0];
    return last_out;
  endfunction

  task automatic model_edge(input logic v, input logic [N-1:0] d,
                            input logic r, input logic rst_v);
    logic acc;
    logic del;
    if (rst_v) begin
      exp_q.delete();
      last_out = '0;
    end else begin
      acc = v && (exp_q.size() < 2);
      del = r && (exp_q.size() > 0);
      if (del) last_out = exp_q.pop_front();
      if (acc) exp_q.push_back(d);
    end
  endtask

  // ---------------- scoreboard checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".occ"},        {30'd0, OCC},            exp_q.size());
    chk({tag, ".dout_valid"}, {31'd0, bus.DOUT_VALID}, {31'd0, exp_q.size() > 0});
    chk({tag, ".din_ready"},  {31'd0, bus.DIN_READY},  {31'd0, exp_q.size() < 2});
    chk({tag, ".dout"},       {24'd0, bus.DOUT},       {24'd0, exp_dout()});
  endtask

  // ---------------- driver ----------------
  // Drive at the falling edge, let one rising edge pass, update the model,
  // then compare at the next falling edge.
  task automatic cycle(input string tag, input logic v, input logic [N-1:0] d,
                       input logic r, input logic rst_v);
    bus.DIN_VALID  = v;
    bus.DIN        = d;
    bus.DOUT_READY = r;
    RST            = rst_v;
    @(posedge CLK);
    model_edge(v, d, r, rst_v);
    @(negedge CLK);
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic         rv;
    logic         rr;
    logic         rrst;
    logic [N-1:0] rd;

    n_pass         = 0;
    n_total        = 0;
    last_out       = '0;
    RST            = 1'b1;
    bus.DIN_VALID  = 1'b0;
    bus.DIN        = '0;
    bus.DOUT_READY = 1'b0;
    @(negedge CLK);

    // Reset held 2 cycles with a word on the input: nothing captured.
    cycle("rst0", 1'b1, 8'hFF, 1'b0, 1'b1);
    cycle("rst1", 1'b1, 8'hFF, 1'b0, 1'b1);
    chk("rst.dout_zero", {24'd0, bus.DOUT}, 32'h00);
    chk("rst.occ_zero",  {30'd0, OCC},      32'd0);
    cycle("idle", 1'b0, 8'hFF, 1'b0, 1'b0);
    chk("idle.no_capture", {31'd0, bus.DOUT_VALID}, 32'd0);

    // Streaming 01..08 with DOUT_READY high throughout.
    for (int i = 1; i <= 8; i++) begin
      cycle("stream", 1'b1, N'(i), 1'b1, 1'b0);
      chk("stream.dout_seq", {24'd0, bus.DOUT}, i);
      chk("stream.occ_one",  {30'd0, OCC},      32'd1);
    end
    cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain.dout_held", {24'd0, bus.DOUT}, 32'h08);

    // Skid: A5 appears, then stall while 5A arrives.
    cycle("skid_a5", 1'b1, 8'hA5, 1'b1, 1'b0);
    cycle("skid_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("skid.occ_full",  {30'd0, OCC},           32'd2);
    chk("skid.din_ready", {31'd0, bus.DIN_READY}, 32'd0);
    chk("skid.dout_a5",   {24'd0, bus.DOUT},      32'hA5);

    // Full hold: 33 offered for 5 cycles while stalled, never taken.
    for (int i = 0; i < 5; i++) begin
      cycle("full_hold", 1'b1, 8'h33, 1'b0, 1'b0);
      chk("full_hold.dout", {24'd0, bus.DOUT}, 32'hA5);
    end

    // Release: A5 then 5A delivered, DIN_READY back after the first.
    cycle("rel0", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel0.dout_5a",    {24'd0, bus.DOUT},      32'h5A);
    chk("rel0.din_ready",  {31'd0, bus.DIN_READY}, 32'd1);
    cycle("rel1", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel1.empty",      {31'd0, bus.DOUT_VALID}, 32'd0);

    // Refill to FULL, then reset mid-operation.
    cycle("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
    cycle("mid_rst", 1'b1, 8'h44, 1'b0, 1'b1);
    chk("mid_rst.occ",   {30'd0, OCC},           32'd0);
    chk("mid_rst.ready", {31'd0, bus.DIN_READY}, 32'd1);
    cycle("post77", 1'b1, 8'h77, 1'b0, 1'b0);
    chk("post77.dout", {24'd0, bus.DOUT}, 32'h77);
    cycle("post77_dlv", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("post77.gone", {31'd0, bus.DOUT_VALID}, 32'd0);

    // Random stress against the FIFO model.
    for (int i = 0; i < 10000; i++) begin
      rv   = 1'($urandom_range(0, 1));
      rr   = ($urandom_range(0, 3) != 0);
      rd   = N'($urandom_range(0, 255));
      rrst = ($urandom_range(0, 999) == 0);
      cycle("rand", rv, rd, rr, rrst);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
